// File: rtl/dm_arb_pkg.sv
// Shared types and defaults for the data-memory arbiter between the core
// load/store path and the external loader/debug port.
package dm_arb_pkg;

  // Which requester held the DM port on the most recent granted cycle.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CORE = 2'd1,
    OWN_EXT  = 2'd2
  } ownerT;

  localparam int unsigned addrWDefault    = 5;
  localparam int unsigned dataWDefault    = 32;
  localparam int unsigned burstMaxDefault = 8;

  // Counter width able to hold 0..maxVal inclusive.
  function automatic int unsigned cntWidth(input int unsigned maxVal);
    return (maxVal < 1) ? 1 : $clog2(maxVal + 1);
  endfunction

endpackage : dm_arb_pkg

// File: rtl/dm_arbiter.sv
// Round-robin arbiter sharing the single-port data memory between the core and
// an external port, with a bounded external burst lock and registered ext reads.
module dm_arbiter
  import dm_arb_pkg::*;
#(
  parameter int unsigned ADDR_W    = addrWDefault,
  parameter int unsigned DATA_W    = dataWDefault,
  parameter int unsigned BURST_MAX = burstMaxDefault
) (
  input  logic              clk,
  input  logic              reset,

  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wd,
  output logic              core_stall,
  output logic [DATA_W-1:0] core_rd,

  input  logic              ext_req,
  input  logic              ext_we,
  input  logic              ext_burst,
  input  logic [ADDR_W-1:0] ext_addr,
  input  logic [DATA_W-1:0] ext_wd,
  output logic              ext_gnt,
  output logic [DATA_W-1:0] ext_rd,
  output logic              ext_rvalid,

  output logic [ADDR_W-1:0] dm_addr,
  output logic [DATA_W-1:0] dm_wd,
  output logic              dm_we,
  input  logic [DATA_W-1:0] dm_rd
);

  localparam int unsigned   CNT_W    = cntWidth(BURST_MAX);
  localparam logic [CNT_W-1:0] BCNT_MAX = CNT_W'(BURST_MAX);

  ownerT            last, lastNext;
  logic             lock, lockNext;
  logic [CNT_W-1:0] bcnt, bcntNext;
  logic             coreGnt, extGnt;
  logic             burstOpen;

  // The ext burst still has budget only while locked and below the cap.
  assign burstOpen = lock && (bcnt < BCNT_MAX);

  // Grant pick. Reset is folded in so nothing reaches DM while it is held low;
  // dm_rd is deliberately absent from this cone.
  // NOTE: every always_comb output gets a default before any branch, otherwise
  // a path that skips the assignment infers a latch.
  always_comb begin : grantPick
    coreGnt = 1'b0;
    extGnt  = 1'b0;
    if (reset) begin
      case ({core_req, ext_req})
        2'b10: coreGnt = 1'b1;
        2'b01: extGnt  = 1'b1;
        2'b11: begin
          if (burstOpen)              extGnt  = 1'b1;
          else if (last == OWN_EXT)   coreGnt = 1'b1;
          else if (last == OWN_CORE)  extGnt  = 1'b1;
          else                        coreGnt = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin : dmMux
    dm_addr = '0;
    dm_wd   = '0;
    dm_we   = 1'b0;
    if (coreGnt) begin
      dm_addr = core_addr;
      dm_wd   = core_wd;
      dm_we   = core_we;
    end else if (extGnt) begin
      dm_addr = ext_addr;
      dm_wd   = ext_wd;
      dm_we   = ext_we;
    end
  end

  assign core_stall = core_req & ~coreGnt;
  assign core_rd    = dm_rd;
  assign ext_gnt    = extGnt;

  // Lock survives only while ext keeps winning with ext_burst high; a core
  // grant, an idle cycle or a dropped burst all end it and clear the count.
  always_comb begin : nextState
    lastNext = last;
    lockNext = extGnt & ext_burst;
    bcntNext = '0;
    if (coreGnt)     lastNext = OWN_CORE;
    else if (extGnt) lastNext = OWN_EXT;
    if (lockNext) begin
      bcntNext = (bcnt == BCNT_MAX) ? bcnt : bcnt + CNT_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin : stateReg
    if (!reset) begin
      last <= OWN_NONE;
      lock <= 1'b0;
      bcnt <= '0;
    end else begin
      last <= lastNext;
      lock <= lockNext;
      bcnt <= bcntNext;
    end
  end

  // Ext read data is captured from the combinational DM read in the grant
  // cycle and presented, with a one-cycle valid pulse, on the next cycle.
  always_ff @(posedge clk or negedge reset) begin : extReadReg
    if (!reset) begin
      ext_rd     <= '0;
      ext_rvalid <= 1'b0;
    end else begin
      ext_rvalid <= extGnt & ~ext_we;
      if (extGnt && !ext_we) begin
        ext_rd <= dm_rd;
      end
    end
  end

endmodule : dm_arbiter

// File: tb/tb_dm_arbiter.sv
// Self-checking bench for dm_arbiter: directed scenarios then constrained-random
// traffic, all compared against a behavioural ownership/memory model.
module tb_dm_arbiter;

  localparam int BURST_MAX = 8;

  typedef struct packed {
    logic        coreReq;
    logic        coreWe;
    logic [4:0]  coreAddr;
    logic [31:0] coreWd;
    logic        extReq;
    logic        extWe;
    logic        extBurst;
    logic [4:0]  extAddr;
    logic [31:0] extWd;
  } stimT;

  logic        clk = 1'b0;
  logic        reset;
  logic        core_req, core_we, core_stall;
  logic [4:0]  core_addr;
  logic [31:0] core_wd, core_rd;
  logic        ext_req, ext_we, ext_burst, ext_gnt, ext_rvalid;
  logic [4:0]  ext_addr;
  logic [31:0] ext_wd, ext_rd;
  logic [4:0]  dm_addr;
  logic [31:0] dm_wd, dm_rd;
  logic        dm_we;

  int nAssert = 0;
  int nFail   = 0;

  // Behavioural model: who owned the port last, how long the current ext
  // burst has run, the expected memory image and the pending ext read.
  int          mLast = 0;  // 0 none, 1 core, 2 ext
  int          mRun  = 0;
  bit          mRv   = 1'b0;
  logic [31:0] mRd   = '0;
  logic [31:0] shadow [32] = '{default: '0};

  // Single-port DM with combinational read and synchronous write.
  logic [31:0] dmem [32] = '{default: '0};
  assign dm_rd = dmem[dm_addr];
  always @(posedge clk) if (dm_we) dmem[dm_addr] <= dm_wd;

  always #5 clk = ~clk;

  dm_arbiter #(.ADDR_W(5), .DATA_W(32), .BURST_MAX(BURST_MAX)) dut (
    .clk        (clk),
    .reset      (reset),
    .core_req   (core_req),
    .core_we    (core_we),
    .core_addr  (core_addr),
    .core_wd    (core_wd),
    .core_stall (core_stall),
    .core_rd    (core_rd),
    .ext_req    (ext_req),
    .ext_we     (ext_we),
    .ext_burst  (ext_burst),
    .ext_addr   (ext_addr),
    .ext_wd     (ext_wd),
    .ext_gnt    (ext_gnt),
    .ext_rd     (ext_rd),
    .ext_rvalid (ext_rvalid),
    .dm_addr    (dm_addr),
    .dm_wd      (dm_wd),
    .dm_we      (dm_we),
    .dm_rd      (dm_rd)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nAssert++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s @%0t: observed %h expected %h", tag, $time, obs, exp);
    end
  endtask

  function automatic stimT mk(input logic cr, input logic cw, input logic [4:0] ca,
                              input logic [31:0] cd, input logic er, input logic ew,
                              input logic eb, input logic [4:0] ea, input logic [31:0] ed);
    stimT s;
    s = '{coreReq: cr, coreWe: cw, coreAddr: ca, coreWd: cd,
          extReq: er, extWe: ew, extBurst: eb, extAddr: ea, extWd: ed};
    return s;
  endfunction

  task automatic drive(input stimT s);
    core_req  = s.coreReq;  core_we  = s.coreWe;  core_addr = s.coreAddr; core_wd = s.coreWd;
    ext_req   = s.extReq;   ext_we   = s.extWe;   ext_burst = s.extBurst;
    ext_addr  = s.extAddr;  ext_wd   = s.extWd;
  endtask

  // Arbitration rules: lone requester wins; on contention an unfinished burst
  // keeps ext, otherwise ownership alternates, core first from a fresh start.
  function automatic void predict(input stimT s, output bit gc, output bit ge);
    gc = 1'b0;
    ge = 1'b0;
    if (s.coreReq && !s.extReq)      gc = 1'b1;
    else if (s.extReq && !s.coreReq) ge = 1'b1;
    else if (s.coreReq && s.extReq) begin
      if (mRun > 0 && mRun < BURST_MAX) ge = 1'b1;
      else if (mLast == 1)              ge = 1'b1;
      else                              gc = 1'b1;
    end
  endfunction

  // One clock cycle: inputs are applied just after a rising edge, outputs are
  // compared at the falling edge, and the model advances at the next rise.
  task automatic cyc(input stimT s, input int expOwn, output bit gc, output bit ge);
    int          own;
    logic        expWe;
    logic [4:0]  expAddr;
    logic [31:0] expWd;
    drive(s);
    @(negedge clk);
    predict(s, gc, ge);
    expWe   = gc ? s.coreWe   : (ge ? s.extWe   : 1'b0);
    expAddr = gc ? s.coreAddr : (ge ? s.extAddr : 5'd0);
    expWd   = gc ? s.coreWd   : (ge ? s.extWd   : 32'd0);
    check("core_stall", 32'(core_stall), 32'(s.coreReq & ~gc));
    check("ext_gnt",    32'(ext_gnt),    32'(ge));
    check("dm_we",      32'(dm_we),      32'(expWe));
    check("dm_addr",    32'(dm_addr),    32'(expAddr));
    check("dm_wd",      dm_wd,           expWd);
    if (gc && !s.coreWe) check("core_rd", core_rd, shadow[s.coreAddr]);
    check("ext_rvalid", 32'(ext_rvalid), 32'(mRv));
    if (mRv) check("ext_rd", ext_rd, mRd);
    if (expOwn >= 0) begin
      own = ext_gnt ? 2 : ((core_req && !core_stall) ? 1 : 0);
      check("owner", 32'(own), 32'(expOwn));
    end
    @(posedge clk);
    mRv = ge && !s.extWe;
    if (mRv) mRd = shadow[s.extAddr];
    if (gc) begin
      if (s.coreWe) shadow[s.coreAddr] = s.coreWd;
      mLast = 1;
      mRun  = 0;
    end else if (ge) begin
      if (s.extWe) shadow[s.extAddr] = s.extWd;
      mLast = 2;
      mRun  = s.extBurst ? ((mRun < BURST_MAX) ? mRun + 1 : mRun) : 0;
    end else begin
      mRun = 0;
    end
    #1;
  endtask

  // Asserts reset with the current inputs left in place, checks the forced
  // outputs immediately and again after an edge, then releases.
  task automatic doReset();
    reset = 1'b0;
    #1;
    check("rst.stall",  32'(core_stall), 32'(core_req));
    check("rst.egnt",   32'(ext_gnt),    32'd0);
    check("rst.dm_we",  32'(dm_we),      32'd0);
    check("rst.dmaddr", 32'(dm_addr),    32'd0);
    check("rst.dmwd",   dm_wd,           32'd0);
    check("rst.rvalid", 32'(ext_rvalid), 32'd0);
    check("rst.ext_rd", ext_rd,          32'd0);
    mLast = 0;
    mRun  = 0;
    mRv   = 1'b0;
    @(posedge clk);
    #1;
    check("rst.rvalid2", 32'(ext_rvalid), 32'd0);
    reset = 1'b1;
  endtask

  initial begin
    stimT s;
    bit   gc, ge, cHold, eHold;

    reset = 1'b1;
    drive(mk(1'b1, 1'b1, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0));
    #2;

    // Reset with core requesting, then the core is served on release.
    doReset();
    cyc(mk(1'b1, 1'b1, 5'd1, 32'h0000_00A5, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0), 1, gc, ge);

    // Core-only store then load of the same word.
    cyc(mk(1'b1, 1'b1, 5'd3, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0), 1, gc, ge);
    cyc(mk(1'b1, 1'b0, 5'd3, 32'd0,         1'b0, 1'b0, 1'b0, 5'd0, 32'd0), 1, gc, ge);
    check("load_deadbeef", shadow[3], 32'hDEAD_BEEF);

    // Contention without burst from a fresh reset alternates C,E,C,E.
    drive(mk(1'b1, 1'b0, 5'd3, 32'd0, 1'b1, 1'b0, 1'b0, 5'd3, 32'd0));
    doReset();
    s = mk(1'b1, 1'b0, 5'd3, 32'd0, 1'b1, 1'b0, 1'b0, 5'd3, 32'd0);
    cyc(s, 1, gc, ge);
    cyc(s, 2, gc, ge);
    cyc(s, 1, gc, ge);
    cyc(s, 2, gc, ge);

    // Ext write then read of word 7; the read data follows one cycle later.
    cyc(mk(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 1'b1, 1'b0, 5'd7, 32'h1234_5678), 2, gc, ge);
    cyc(mk(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 1'b0, 5'd7, 32'd0),         2, gc, ge);
    cyc(mk(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0),         0, gc, ge);
    check("ext_rd_0x12345678", ext_rd, 32'h1234_5678);

    // Burst under contention: core once, BURST_MAX ext grants, core, ext.
    s = mk(1'b1, 1'b0, 5'd3, 32'd0, 1'b1, 1'b0, 1'b1, 5'd7, 32'd0);
    cyc(s, 1, gc, ge);
    for (int i = 0; i < BURST_MAX; i++) cyc(s, 2, gc, ge);
    cyc(s, 1, gc, ge);
    cyc(s, 2, gc, ge);

    // Ext-only burst well past the cap stays granted; contention then goes to core.
    s = mk(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 1'b1, 1'b1, 5'd9, 32'h0BAD_F00D);
    for (int i = 0; i < 2 * BURST_MAX; i++) cyc(s, 2, gc, ge);
    cyc(mk(1'b1, 1'b0, 5'd9, 32'd0, 1'b1, 1'b1, 1'b1, 5'd9, 32'h0BAD_F00D), 1, gc, ge);
    cyc(mk(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0), 0, gc, ge);

    // Reset mid-burst after five ext reads with a read still pending.
    s = mk(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 1'b1, 5'd7, 32'd0);
    for (int i = 0; i < 5; i++) cyc(s, 2, gc, ge);
    core_req = 1'b1;
    doReset();
    s = mk(1'b1, 1'b0, 5'd3, 32'd0, 1'b1, 1'b0, 1'b1, 5'd7, 32'd0);
    cyc(s, 1, gc, ge);
    cyc(s, 2, gc, ge);

    // Random traffic; each side holds its request until it is granted.
    cHold = 1'b0;
    eHold = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (!cHold) begin
        s.coreReq  = 1'($urandom_range(0, 1));
        s.coreWe   = 1'($urandom_range(0, 1));
        s.coreAddr = 5'($urandom_range(0, 31));
        s.coreWd   = $urandom;
      end
      if (!eHold) begin
        s.extReq   = ($urandom_range(0, 3) != 0);
        s.extWe    = 1'($urandom_range(0, 1));
        s.extBurst = ($urandom_range(0, 3) != 0);
        s.extAddr  = 5'($urandom_range(0, 31));
        s.extWd    = $urandom;
      end
      cyc(s, -1, gc, ge);
      cHold = s.coreReq && !gc;
      eHold = s.extReq && !ge;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

endmodule : tb_dm_arbiter
